// File: rtl/mem_access_ctrl_if.sv
// Memory-stage bus bundle: XM pipeline inputs, data-memory handshake and MW outputs.
interface mem_access_ctrl_if;
    localparam int unsigned DATA_W = 16;

    logic              XM_memRead;
    logic              XM_memWrite;
    logic [DATA_W-1:0] XM_aluOut;
    logic [DATA_W-1:0] XM_writeData;
    logic              XM_halt;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              stall;
    logic [DATA_W-1:0] MW_readData;
    logic              rdata_valid;
    logic              err;
    logic              halted;

    // Controller side
    modport slave (
        input  XM_memRead, XM_memWrite, XM_aluOut, XM_writeData, XM_halt,
        input  mem_rdata, mem_done,
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        output stall, MW_readData, rdata_valid, err, halted
    );

    // Pipeline / memory side
    modport master (
        output XM_memRead, XM_memWrite, XM_aluOut, XM_writeData, XM_halt,
        output mem_rdata, mem_done,
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        input  stall, MW_readData, rdata_valid, err, halted
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: issues one load/store per instruction, stalls upstream
// while the multi-cycle memory access is outstanding, and flags bad or timed-out accesses.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_ctrl_if.slave   bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              r_err, w_err_nxt;
    logic              r_halted, w_halted_nxt;
    logic              r_is_load, w_is_load_nxt;
    logic              w_op;
    logic              w_stall;
    logic              w_rd;
    logic              w_wr;
    logic              w_rvalid;

    // State and data registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_halted  <= 1'b0;
            r_is_load <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rdata   <= w_rdata_nxt;
            r_err     <= w_err_nxt;
            r_halted  <= w_halted_nxt;
            r_is_load <= w_is_load_nxt;
        end
    end

    // Next-state, request strobes, stall and error/halt decisions
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rdata_nxt   = r_rdata;
        w_err_nxt     = r_err;
        w_halted_nxt  = r_halted;
        w_is_load_nxt = r_is_load;
        w_stall       = 1'b0;
        w_rd          = 1'b0;
        w_wr          = 1'b0;
        w_rvalid      = 1'b0;
        w_op          = (bus.XM_memRead | bus.XM_memWrite) & ~r_halted;

        case (r_state)
            S_IDLE: begin
                if (w_op) begin
                    if ((bus.XM_memRead & bus.XM_memWrite) | bus.XM_aluOut[0]) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_rd          = bus.XM_memRead;
                        w_wr          = bus.XM_memWrite;
                        w_stall       = 1'b1;
                        w_cnt_nxt     = '0;
                        w_is_load_nxt = bus.XM_memRead;
                        w_state_nxt   = S_WAIT;
                    end
                end else if (bus.XM_halt) begin
                    w_halted_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
                if (bus.mem_done) begin
                    if (r_is_load) begin
                        w_rdata_nxt = bus.mem_rdata;
                    end
                    w_state_nxt = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = '0;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_rvalid    = r_is_load;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Strobes and stall drop immediately while reset is held
    assign bus.stall       = rst & w_stall;
    assign bus.mem_rd      = rst & w_rd;
    assign bus.mem_wr      = rst & w_wr;
    assign bus.rdata_valid = rst & w_rvalid;
    assign bus.mem_addr    = bus.XM_aluOut;
    assign bus.mem_wdata   = bus.XM_writeData;
    assign bus.MW_readData = r_rdata;
    assign bus.err         = r_err;
    assign bus.halted      = r_halted;
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage controller that consumes the execute/memory pipeline-register outputs and drives a multi-cycle data memory with a request/done handshake. It issues one load or store per memory-stage instruction and freezes the upstream pipeline while the access is outstanding. It then presents load data to the memory/writeback register and flags misaligned, illegal or timed-out accesses. It sits between the XM pipeline register and the MW pipeline register.

## Interface
- TIMEOUT, 64: wait-state cycles allowed before an access is abandoned (2..255).
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- XM_memRead  in  1  current memory-stage instruction is a load.
- XM_memWrite  in  1  current memory-stage instruction is a store.
- XM_aluOut  in  16  effective byte address.
- XM_writeData  in  16  store data.
- XM_halt  in  1  current memory-stage instruction is HALT.
- mem_addr  out  16  memory address; equals XM_aluOut.
- mem_wdata  out  16  memory write data; equals XM_writeData.
- mem_rd  out  1  read request strobe, one cycle.
- mem_wr  out  1  write request strobe, one cycle.
- mem_rdata  in  16  memory read data, valid with mem_done.
- mem_done  in  1  access-complete pulse from memory.
- stall  out  1  freeze PC, FD, DX and XM registers this cycle.
- MW_readData  out  16  captured load data for the MW register.
- rdata_valid  out  1  one-cycle pulse: MW_readData is valid for the instruction leaving XM.
- err  out  1  sticky error flag.
- halted  out  1  sticky halt flag.

## Operation
- States: IDLE, WAIT, DONE. The reset state is IDLE.
- An operation is "op" = (XM_memRead | XM_memWrite) & ~halted.
- IDLE, no op: stall=0. No request is issued. The state stays IDLE.
- IDLE, op with both XM_memRead and XM_memWrite=1 (illegal): set err. No request is issued. stall=0. The state stays IDLE.
- IDLE, op with XM_aluOut[0]=1 (misaligned word access): set err. No request is issued. stall=0. The state stays IDLE.
- IDLE, legal op:
  - mem_rd=XM_memRead and mem_wr=XM_memWrite, asserted combinationally.
  - stall=1. The wait counter clears to 0. Next state is WAIT.
- WAIT:
  - stall=1. mem_rd and mem_wr stay 0. The counter increments each cycle, saturating at 8 bits.
  - If mem_done=1: for a load, capture mem_rdata into MW_readData. Next state is DONE.
  - Else, if the counter equals TIMEOUT-1: set err. MW_readData is forced to 0x0000. Next state is DONE.
- DONE:
  - stall=0. rdata_valid=1 for a load (including a timed-out load), 0 for a store.
  - No request is issued. Next state is IDLE.
- The XM inputs are held stable by the stall from IDLE through WAIT. mem_done outside WAIT is ignored.
- HALT: in IDLE with XM_halt=1 and no op, set halted. While halted, all ops are ignored and no requests are issued.
- err and halted clear only on reset.

## Timing
- Reset (rst=0) takes effect immediately, asynchronously:
  - state=IDLE, counter=0, MW_readData=0x0000, err=0, halted=0.
  - stall, mem_rd, mem_wr and rdata_valid are 0.
- A reset in the middle of WAIT drops stall and any strobe at once. A mem_done arriving afterwards is ignored.
- Access latency is 1 (IDLE issue) + N (WAIT cycles, N≥1) + 1 (DONE) cycles. stall is high for the first 1+N of these.
- The earliest mem_done is the first WAIT cycle, which gives a minimum of 3 cycles per memory instruction.
- MW_readData is registered. It updates on the edge that leaves WAIT and holds until the next load completes.
- mem_done together with the timeout cycle: mem_done wins and err is not set.
- mem_addr and mem_wdata are combinational pass-throughs at all times.

## Test plan
- Load, addr 0x0010, memory returns 0xBEEF with mem_done on the 2nd WAIT cycle -> mem_rd high for 1 cycle, stall high for 3 cycles, then rdata_valid=1 and MW_readData=0xBEEF in DONE.
- Store, addr 0x0020, data 0x1234, mem_done on the 1st WAIT cycle -> mem_wr for 1 cycle with mem_wdata=0x1234, stall for 2 cycles, rdata_valid stays 0.
- Load at 0x0011 -> err=1 next cycle, no strobe, stall=0. Both read and write asserted -> same response.
- TIMEOUT=4, load with mem_done never asserted -> err set after 4 WAIT cycles, MW_readData=0x0000, rdata_valid pulse, then return to IDLE.
- HALT in IDLE, then a load -> halted=1, and the load issues no mem_rd and no stall.
- rst dropped to 0 during WAIT -> stall and err are 0 immediately. A later mem_done causes no capture, and MW_readData stays 0x0000.
